// File: rtl/sfifo_arb_pkg.sv
// Shared definitions for the sfifo write-side arbiter.
//   arb_state_t   : arbiter FSM encoding (IDLE = 0, GRANTED = 1)
//   DEF_MAXBURST  : default beats per grant before forced re-arbitration
package sfifo_arb_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_t;

    localparam int DEF_MAXBURST = 16;

endpackage

// File: rtl/sfifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   i_req      : request vector, one bit per producer
//   i_last_idx : index of the most recently served producer; the search
//                starts at i_last_idx+1 and wraps, so i_last_idx is lowest
//   o_onehot   : one-hot winner (0 when no request)
//   o_idx      : binary index of the winner (0 when no request)
//   o_any      : at least one request present
module rr_pick #(
    parameter int NIN   = 4,
    parameter int LGNIN = 2
) (
    input  logic [NIN-1:0]   i_req,
    input  logic [LGNIN-1:0] i_last_idx,
    output logic [NIN-1:0]   o_onehot,
    output logic [LGNIN-1:0] o_idx,
    output logic             o_any
);

    logic [LGNIN-1:0] w_pos;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_pos    = i_last_idx;
        // Walk NIN positions starting just after the last served producer;
        // the position counter wraps at NIN so non-power-of-two NIN works.
        for (int k = 0; k < NIN; k++) begin
            w_pos = (w_pos == LGNIN'(NIN - 1)) ? '0 : w_pos + 1'b1;
            if (!o_any && i_req[w_pos]) begin
                o_any           = 1'b1;
                o_onehot[w_pos] = 1'b1;
                o_idx           = w_pos;
            end
        end
    end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one sfifo write port among NIN
// producers. A grant is held for a whole packet (or MAXBURST beats) and the
// FIFO write carries {source index, data}.
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_req_valid/data/last, o_req_ready : per-producer valid/ready streams
//   o_fifo_wr, o_fifo_data, i_fifo_full : sfifo write port
//   o_grant : one-hot current grant, o_busy : a grant is active
module sfifo_wr_arbiter
    import sfifo_arb_pkg::*;
#(
    parameter int NIN             = 4,
    parameter int LGNIN           = 2,
    parameter int BW              = 8,
    parameter int MAXBURST        = DEF_MAXBURST,
    parameter bit OPT_PACKET_LOCK = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NIN-1:0]       i_req_valid,
    input  logic [NIN*BW-1:0]    i_req_data,
    input  logic [NIN-1:0]       i_req_last,
    output logic [NIN-1:0]       o_req_ready,
    output logic                 o_fifo_wr,
    output logic [BW+LGNIN-1:0]  o_fifo_data,
    input  logic                 i_fifo_full,
    output logic [NIN-1:0]       o_grant,
    output logic                 o_busy
);

    localparam int BCW = $clog2(MAXBURST + 1);

    arb_state_t       r_state;
    logic [NIN-1:0]   r_grant;
    logic [LGNIN-1:0] r_gidx;
    logic [LGNIN-1:0] r_last_idx;
    logic [BCW-1:0]   r_bcnt;

    logic [BW-1:0]    w_lane [NIN];
    logic             w_granted;
    logic             w_xfer;
    logic             w_release;
    logic [NIN-1:0]   w_pick_req;
    logic [LGNIN-1:0] w_pick_ptr;
    logic [NIN-1:0]   w_win;
    logic [LGNIN-1:0] w_win_idx;
    logic             w_any;

    for (genvar gi = 0; gi < NIN; gi++) begin : g_lane
        assign w_lane[gi] = i_req_data[gi*BW +: BW];
    end

    assign w_granted = (r_state == ST_GRANTED);
    assign w_xfer    = w_granted && i_req_valid[r_gidx] && !i_fifo_full;
    assign w_release = w_xfer && (i_req_last[r_gidx] ||
                                  (r_bcnt == BCW'(MAXBURST - 1)) ||
                                  !OPT_PACKET_LOCK);

    // While granted, the picker result is only consumed on the releasing
    // beat, where the round-robin pointer becomes r_gidx. The granted
    // lane's valid in that cycle belongs to the beat being consumed, not
    // to a fresh request, so it is masked out of the next arbitration.
    assign w_pick_ptr = w_granted ? r_gidx : r_last_idx;
    assign w_pick_req = i_req_valid & ~(w_granted ? r_grant : '0);

    rr_pick #(
        .NIN   (NIN),
        .LGNIN (LGNIN)
    ) u_pick (
        .i_req      (w_pick_req),
        .i_last_idx (w_pick_ptr),
        .o_onehot   (w_win),
        .o_idx      (w_win_idx),
        .o_any      (w_any)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_last_idx <= LGNIN'(NIN - 1);
            r_bcnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANTED;
                        r_grant <= w_win;
                        r_gidx  <= w_win_idx;
                        r_bcnt  <= '0;
                    end
                end
                ST_GRANTED: begin
                    if (w_release) begin
                        r_last_idx <= r_gidx;
                        r_bcnt     <= '0;
                        if (w_any) begin
                            r_grant <= w_win;
                            r_gidx  <= w_win_idx;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                        end
                    end else if (w_xfer) begin
                        r_bcnt <= r_bcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = w_granted;
    assign o_fifo_wr   = w_xfer;
    assign o_req_ready = (w_granted && !i_fifo_full) ? r_grant : '0;
    assign o_fifo_data = {r_gidx, w_lane[r_gidx]};

endmodule
